// File: rtl/mem_access_ctrl_pkg.sv
// Shared LC-3 memory-access definitions: op encodings, sequencer states and
// condition-code helpers, also reused by the register-file CC logic.
package lc3_mem_pkg;

    localparam int LC3_ADDR_W = 16;
    localparam int LC3_DATA_W = 16;

    localparam logic [1:0] OP_LOAD      = 2'b00;
    localparam logic [1:0] OP_STORE     = 2'b01;
    localparam logic [1:0] OP_LOAD_IND  = 2'b10;
    localparam logic [1:0] OP_STORE_IND = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PTR    = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    function automatic logic [2:0] calc_nzp(input logic [LC3_DATA_W-1:0] word);
        if (word[LC3_DATA_W-1]) return NZP_N;
        if (word == '0)         return NZP_Z;
        return NZP_P;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Execute-side request/response and data-memory port of the load/store sequencer.
// Handshake: start is taken only while busy=0; each accepted request ends with
// exactly one done pulse (unless reset aborts it); no requests are queued.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] st_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] load_data;
    logic [2:0]        nzp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport slave (
        input  start, op, ea, st_data, read_data,
        output busy, done, load_data, nzp, mem_read, mem_write, addr, write_data
    );

    modport master (
        output start, op, ea, st_data, read_data,
        input  busy, done, load_data, nzp, mem_read, mem_write, addr, write_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3 load/store sequencer: direct ops take one memory access, LDI/STI first
// fetch the pointer word and then access the address it holds.
module mem_access_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = LC3_ADDR_W,
    parameter int DATA_W = LC3_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_ctrl_if.slave   bus,
    output state_t             state_dbg_o
);

    state_t            state_q,     state_d;
    logic [1:0]        op_q,        op_d;
    logic [ADDR_W-1:0] ea_q,        ea_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] st_q,        st_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic [2:0]        nzp_q,       nzp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            ea_q        <= '0;
            addr_q      <= '0;
            st_q        <= '0;
            load_data_q <= '0;
            nzp_q       <= NZP_Z;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ea_q        <= ea_d;
            addr_q      <= addr_d;
            st_q        <= st_d;
            load_data_q <= load_data_d;
            nzp_q       <= nzp_d;
        end
    end

    // Memory-side outputs are decoded from registered state only, so a
    // reset drops mem_write before the pending edge can commit it.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        ea_d           = ea_q;
        addr_d         = addr_q;
        st_d           = st_q;
        load_data_d    = load_data_q;
        nzp_d          = nzp_q;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.addr       = '0;
        bus.write_data = '0;
        bus.done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    ea_d    = bus.ea;
                    addr_d  = bus.ea;
                    st_d    = bus.st_data;
                    state_d = bus.op[1] ? ST_PTR : ST_ACCESS;
                end
            end
            ST_PTR: begin
                bus.mem_read = 1'b1;
                bus.addr     = ea_q;
                addr_d       = bus.read_data;
                state_d      = ST_ACCESS;
            end
            ST_ACCESS: begin
                bus.addr = addr_q;
                if (op_q[0]) begin
                    bus.mem_write  = 1'b1;
                    bus.write_data = st_q;
                end else begin
                    bus.mem_read = 1'b1;
                    load_data_d  = bus.read_data;
                    nzp_d        = calc_nzp(bus.read_data);
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.load_data = load_data_q;
    assign bus.nzp       = nzp_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed LC-3 load/store cases, reset abort and
// randomized ops checked against a word-level memory model.
module tb_mem_access_ctrl;
  import lc3_mem_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();
  state_t state_dbg;

  mem_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .state_dbg_o(state_dbg)
  );

  // data memory attached to the DUT
  logic [15:0] mem [0:65535];
  assign bus.read_data = bus.mem_read ? mem[bus.addr] : 16'h0000;
  always @(posedge clk) if (rst_n && bus.mem_write) mem[bus.addr] <= bus.write_data;

  // reference model state
  logic [15:0] ref_mem [0:65535];
  logic [15:0] ref_ld;
  logic [2:0]  ref_nzp;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [34:0] exp_q[$];   // {done cycle[15:0], load_data, nzp}
  logic [32:0] acc_q[$];   // {is_write, addr, write_data}

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [2:0] ref_flags(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0) return 3'b010;
    return 3'b001;
  endfunction

  // predict accesses and final response of one op accepted at the next edge
  task automatic model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] target;
    int lat;
    target = a;
    lat = 1;
    if (o[1]) begin
      acc_q.push_back({1'b0, a, 16'h0000});
      target = ref_mem[a];
      lat = 2;
    end
    if (o[0]) begin
      acc_q.push_back({1'b1, target, d});
      ref_mem[target] = d;
    end else begin
      acc_q.push_back({1'b0, target, 16'h0000});
      ref_ld = ref_mem[target];
      ref_nzp = ref_flags(ref_ld);
    end
    exp_q.push_back({16'(cyc + 1 + lat), ref_ld, ref_nzp});
  endtask

  // driver
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy) begin
      check("driver_timeout", 35'd1, 35'd0);
      return;
    end
    bus.start = 1'b1;
    bus.op = o;
    bus.ea = a;
    bus.st_data = d;
    model(o, a, d);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom);
    bus.ea = 16'($urandom);
    bus.st_data = 16'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0 || bus.busy) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain_exp_q_empty", 35'(exp_q.size()), 35'd0);
    check("drain_acc_q_empty", 35'(acc_q.size()), 35'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [32:0] ea_e;
    logic [34:0] ed;
    if (rst_n) begin
      if (bus.mem_read || bus.mem_write) begin
        check("rw_exclusive", 35'(bus.mem_read & bus.mem_write), 35'd0);
        if (acc_q.size() == 0) begin
          check("unexpected_access", {2'b0, bus.mem_write, bus.addr, bus.write_data}, 35'd0);
        end else begin
          ea_e = acc_q.pop_front();
          check("mem_access", 35'({bus.mem_write, bus.addr, bus.mem_write ? bus.write_data : 16'h0000}),
                35'(ea_e));
        end
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 35'd1, 35'd0);
        end else begin
          ed = exp_q.pop_front();
          check("done_cycle", 35'(cyc[15:0]), 35'(ed[34:19]));
          check("load_data", 35'(bus.load_data), 35'(ed[18:3]));
          check("nzp", 35'(bus.nzp), 35'(ed[2:0]));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [1:0]  o;
    logic [15:0] a;
    logic [15:0] d;
    int r;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.ea = 16'h0000;
    bus.st_data = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    mem[16'h300C] = 16'h0000; ref_mem[16'h300C] = 16'h0000;
    mem[16'h300D] = 16'h000A; ref_mem[16'h300D] = 16'h000A;
    mem[16'h3010] = 16'h300D; ref_mem[16'h3010] = 16'h300D;
    mem[16'h3011] = 16'h4000; ref_mem[16'h3011] = 16'h4000;
    ref_ld = 16'h0000;
    ref_nzp = 3'b010;

    // reset values
    #2 rst_n = 1'b0;
    #2;
    check("rst_busy", 35'(bus.busy), 35'd0);
    check("rst_done", 35'(bus.done), 35'd0);
    check("rst_mem_read", 35'(bus.mem_read), 35'd0);
    check("rst_mem_write", 35'(bus.mem_write), 35'd0);
    check("rst_addr", 35'(bus.addr), 35'd0);
    check("rst_write_data", 35'(bus.write_data), 35'd0);
    check("rst_load_data", 35'(bus.load_data), 35'd0);
    check("rst_nzp", 35'(bus.nzp), 35'b010);
    check("rst_state", 35'(state_dbg), 35'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed program
    issue(OP_LOAD, 16'h300D, 16'h0000);
    issue(OP_LOAD, 16'h300C, 16'h0000);
    issue(OP_STORE, 16'h300C, 16'h8001);
    issue(OP_LOAD, 16'h300C, 16'h0000);
    issue(OP_LOAD_IND, 16'h3010, 16'h0000);
    issue(OP_STORE_IND, 16'h3011, 16'hBEEF);
    drain();
    check("mem_x4000", 35'(mem[16'h4000]), 35'h0BEEF);
    check("mem_x300C", 35'(mem[16'h300C]), 35'h08001);

    // start while busy must be dropped, not queued
    issue(OP_LOAD, 16'h300D, 16'h0000);
    bus.start = 1'b1;
    bus.op = OP_STORE;
    bus.ea = 16'h5555;
    bus.st_data = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // reset during the pointer read of a STORE_IND
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_STORE_IND;
    bus.ea = 16'h3011;
    bus.st_data = 16'h1234;
    acc_q.push_back({1'b0, 16'h3011, 16'h0000});
    @(negedge clk);
    bus.start = 1'b0;
    check("ptr_busy", 35'(bus.busy), 35'd1);
    check("ptr_mem_read", 35'(bus.mem_read), 35'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 35'(bus.busy), 35'd0);
    check("abort_mem_read", 35'(bus.mem_read), 35'd0);
    check("abort_mem_write", 35'(bus.mem_write), 35'd0);
    check("abort_addr", 35'(bus.addr), 35'd0);
    check("abort_done", 35'(bus.done), 35'd0);
    check("abort_nzp", 35'(bus.nzp), 35'b010);
    check("abort_load_data", 35'(bus.load_data), 35'd0);
    ref_ld = 16'h0000;
    ref_nzp = 3'b010;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_write", 35'(mem[16'h4000]), 35'h0BEEF);
    drain();

    // randomized ops over a small address pool including both address extremes
    mem[16'h3000] = 16'hFFFF; ref_mem[16'h3000] = 16'hFFFF;
    mem[16'h3001] = 16'h0000; ref_mem[16'h3001] = 16'h0000;
    for (int i = 2; i < 8; i++) begin
      d = 16'h3000 + 16'($urandom_range(0, 7));
      mem[16'h3000 + 16'(i)] = d;
      ref_mem[16'h3000 + 16'(i)] = d;
    end
    for (int n = 0; n < 80; n++) begin
      o = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      a = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'h3000 + 16'(r - 2);
      case ($urandom_range(0, 3))
        0: d = 16'h0000;
        1: d = 16'h8000 | 16'($urandom);
        2: d = 16'h3000 + 16'($urandom_range(0, 7));
        default: d = 16'($urandom);
      endcase
      issue(o, a, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("ignored_store_x5555", 35'(mem[16'h5555]), 35'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
